// File: rtl/decode_arb_pkg.sv
// Shared types and constants for the decode-stage arbiter slice.
package decode_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_IDX_W          = 2;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  // Result word returned to a requester whose instruction never completed
  localparam logic [31:0] TIMEOUT_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_RESULT = 3'd2,
    S_RETURN      = 3'd3,
    S_ACK_DEC     = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first request after i_ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_grant_idx_c,
  output logic               o_any_grant_c
);

  localparam int unsigned CW = IDX_W + 1;

  logic [CW-1:0] w_cand;

  // Walk from lowest to highest priority so the nearest request after i_ptr wins
  always_comb begin
    o_any_grant_c = 1'b0;
    o_grant_idx_c = '0;
    o_grant_c     = '0;
    w_cand        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = {1'b0, i_ptr} + CW'(i);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (i_en && i_req[w_cand[IDX_W-1:0]]) begin
        o_any_grant_c = 1'b1;
        o_grant_idx_c = w_cand[IDX_W-1:0];
      end
    end
    if (o_any_grant_c) begin
      o_grant_c[o_grant_idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage_arbiter.sv
// Shares one MIPS32 decode/execute stage between NUM_REQ sources, one instruction in flight.
// Optional watchdog enabled by defining DECODE_STAGE_ARBITER_TIMEOUT_EN.
module decode_stage_arbiter
  import decode_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned IDX_W          = DEF_IDX_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic [NUM_REQ-1:0]        rsp_ack,
  output logic                      dec_dir,
  output logic [DATA_W-1:0]         dec_data,
  input  logic                      dec_ack_prev,
  input  logic                      dec_dor,
  input  logic [DATA_W-1:0]         dec_result,
  output logic                      dec_ack_next,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner_idx
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("decode_stage_arbiter: unsupported parameter set");
  end

  arb_state_e           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_owner;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_dec_dir;
  logic [DATA_W-1:0]    r_dec_data;
  logic                 r_dec_ack_next;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_any_grant;
  logic [DATA_W-1:0]    w_sel_data;
  logic [NUM_REQ-1:0]   w_owner_onehot;
  logic                 w_owner_ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req         (req_valid),
    .i_ptr         (r_ptr),
    .i_en          (r_state == S_IDLE),
    .o_grant_c     (w_grant),
    .o_grant_idx_c (w_grant_idx),
    .o_any_grant_c (w_any_grant)
  );

  // Instruction slice of the winning requester
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_owner_onehot = NUM_REQ'(1) << r_owner;
  assign w_owner_ack    = rsp_ack[r_owner];

`ifdef DECODE_STAGE_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_timeout;
  logic             w_progress;

  // Fires on the edge that completes TIMEOUT_CYCLES cycles since ISSUE entry
  assign w_timeout  = (r_tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_progress = (r_state == S_ISSUE && dec_ack_prev) ||
                      (r_state == S_WAIT_RESULT && dec_dor);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_ptr          <= IDX_W'(NUM_REQ - 1);
      r_owner        <= '0;
      r_req_ack      <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_dec_dir      <= 1'b0;
      r_dec_data     <= '0;
      r_dec_ack_next <= 1'b0;
      r_busy         <= 1'b0;
`ifdef DECODE_STAGE_ARBITER_TIMEOUT_EN
      r_tmo_cnt      <= '0;
`endif
    end else begin
      r_req_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_grant) begin
            r_req_ack  <= w_grant;
            r_dec_data <= w_sel_data;
            r_owner    <= w_grant_idx;
            r_ptr      <= w_grant_idx;
            r_dec_dir  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
`ifdef DECODE_STAGE_ARBITER_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (dec_ack_prev) begin
            r_dec_dir <= 1'b0;
            r_state   <= S_WAIT_RESULT;
          end
        end
        S_WAIT_RESULT: begin
          if (dec_dor) begin
            r_rsp_data  <= dec_result;
            r_rsp_valid <= w_owner_onehot;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RETURN;
          end
        end
        S_RETURN: begin
          if (w_owner_ack) begin
            r_rsp_valid    <= '0;
            r_dec_ack_next <= 1'b1;
            r_state        <= S_ACK_DEC;
`ifdef DECODE_STAGE_ARBITER_TIMEOUT_EN
            // Decoder never produced a result, so there is nothing to acknowledge
            if (r_rsp_err) begin
              r_rsp_err      <= 1'b0;
              r_dec_ack_next <= 1'b0;
              r_busy         <= 1'b0;
              r_state        <= S_IDLE;
            end
`endif
          end
        end
        S_ACK_DEC: begin
          if (!dec_dor) begin
            r_dec_ack_next <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
`ifdef DECODE_STAGE_ARBITER_TIMEOUT_EN
      if (r_state == S_ISSUE || r_state == S_WAIT_RESULT) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        if (w_timeout && !w_progress) begin
          r_dec_dir   <= 1'b0;
          r_rsp_data  <= DATA_W'(TIMEOUT_ERR_DATA);
          r_rsp_err   <= 1'b1;
          r_rsp_valid <= w_owner_onehot;
          r_state     <= S_RETURN;
        end
      end
`endif
    end
  end

  assign req_ack      = r_req_ack;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign dec_dir      = r_dec_dir;
  assign dec_data     = r_dec_data;
  assign dec_ack_next = r_dec_ack_next;
  assign busy         = r_busy;
  assign owner_idx    = r_owner;

endmodule

// File: doc/decode_stage_arbiter.md
Name: decode_stage_arbiter

Overview:
- Shares the single MIPS32 instruction decode/execute stage between NUM_REQ instruction sources (fetch units, test injectors, debug port).
- Arbitrates round-robin and drives the decoder's DIR/data_in input handshake.
- Collects the decoder's DOR/data_out result, routes it back to the requester that issued the instruction, then returns ack_from_next to the decoder.
- Exactly one instruction is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of requester index (clog2 NUM_REQ)
DATA_W, 32, instruction/result width
TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester instruction valid; level, held until req_ack
req_data  in  NUM_REQ*DATA_W  packed instructions; slice i belongs to requester i
req_ack  out  NUM_REQ  one-hot, one-cycle pulse on grant
rsp_valid  out  NUM_REQ  one-hot result valid; held until rsp_ack of owner
rsp_data  out  DATA_W  result bus, shared by all requesters
rsp_err  out  1  result is a timeout error (0 when feature is compiled out)
rsp_ack  in  NUM_REQ  per-requester result accept
dec_dir  out  1  to decoder DIR
dec_data  out  DATA_W  to decoder data_in
dec_ack_prev  in  1  from decoder ack_prev
dec_dor  in  1  from decoder DOR
dec_result  in  DATA_W  from decoder data_out
dec_ack_next  out  1  to decoder ack_from_next
busy  out  1  high in every state except IDLE
owner_idx  out  IDX_W  index of the current/last granted requester

Behaviour:
- Reset (reset_n=0 at posedge):
  - State goes to IDLE.
  - Every output goes to 0.
  - RR pointer goes to NUM_REQ-1, so requester 0 wins first.
  - Captured instruction register goes to 0.
  - Reset mid-operation abandons the in-flight instruction with no response. The decoder must be reset in the same cycle (system requirement).
- IDLE:
  - If any req_valid is set, grant g = first set bit searching from pointer+1 with wrap-around.
  - Same edge: req_ack[g]=1 for one cycle, dec_data captures req_data[g], owner_idx=g, pointer=g, go to ISSUE.
  - No requests: stay in IDLE.
  - Grant latency is 1 cycle from req_valid.
- ISSUE:
  - dec_dir=1 and dec_data held stable.
  - On dec_ack_prev=1: dec_dir=0, go to WAIT_RESULT.
  - dec_ack_prev is only sampled in ISSUE.
- WAIT_RESULT:
  - On dec_dor=1: capture dec_result into rsp_data, rsp_valid[owner]=1, rsp_err=0, go to RETURN.
- RETURN:
  - Hold rsp_valid/rsp_data until rsp_ack[owner]=1, then clear rsp_valid, go to ACK_DEC.
  - rsp_ack bits of non-owners are ignored.
  - rsp_ack asserted in the same cycle rsp_valid rises is not seen. The earliest accept is the next edge.
- ACK_DEC:
  - dec_ack_next=1 and held until dec_dor samples 0, then dec_ack_next=0, go to IDLE.
  - This guarantees the decoder has left its wait-ack state before the next DIR.
- Fairness:
  - A requester holding req_valid continuously is granted at most once per NUM_REQ grants when others are pending.
  - A requester may re-request immediately after its rsp_ack.
- Input rules:
  - req_valid dropped before req_ack is legal; the request is withdrawn.
  - req_data must be stable while req_valid=1.
- Timing: minimum transaction is IDLE->ISSUE->WAIT->RETURN->ACK->IDLE, i.e. 5 cycles plus decoder latency.

Optional Feature:
- Macro: DECODE_STAGE_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES)+1) clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_RESULT.
  - On reaching TIMEOUT_CYCLES: dec_dir=0, rsp_data=32'hDEADBEEF, rsp_err=1, rsp_valid[owner]=1, go to RETURN.
  - After rsp_ack, go to IDLE directly, skipping ACK_DEC. This covers opcodes the decoder accepts but never completes.
- Undefined: no counter; rsp_err tied 0; the arbiter waits indefinitely.

Decomposition:
- Package decode_arb_pkg holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT_RESULT=2, RETURN=3, ACK_DEC=4; 3-bit)
  - timeout error constant 32'hDEADBEEF
  - default NUM_REQ/DATA_W
- Sub-module rr_arbiter:
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant, grant index, any_grant
  - purely combinational search; pointer register stays in the parent.

Test Plan:
- Single request: requester 2 sends 32'h01095020 (add $t2,$t0,$t1) -> req_ack[2] one cycle after req_valid; dec_dir until dec_ack_prev; rsp_valid[2] with decoder result; dec_ack_next until dec_dor=0; busy back to 0.
- Contention: req_valid=4'b1111 held after reset -> grant order 0,1,2,3,0 and each rsp_valid bit matches the granted index.
- Back-pressure: owner 1 delays rsp_ack 7 cycles while rsp_ack[0]=1 -> rsp_valid[1] and rsp_data stable for 7 cycles; no dec_ack_next until rsp_ack[1]; rsp_ack[0] ignored.
- Reset mid-operation: reset_n=0 during WAIT_RESULT -> next cycle all outputs 0, state IDLE; after release with req_valid=4'b1000 and pointer at 3 -> requester 3 is granted.
- Withdrawn request: req_valid[1] pulses for 0 cycles before grant and req_valid[3] is held -> only requester 3 is acked.
- Timeout (macro defined, TIMEOUT_CYCLES=16): decoder never asserts dec_dor -> 16 cycles after ISSUE entry rsp_valid[owner]=1, rsp_data=32'hDEADBEEF, rsp_err=1, and no dec_ack_next is issued.
